// File: rtl/ii_read_arbiter.sv
// Round-robin arbiter sharing the integral-image BRAM read port among N_REQ requesters.
// Optional out-of-range address trapping is enabled with `define II_ARB_BOUND_CHECK_EN.
module ii_read_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_ADDR = 19199
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_frame_valid,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic [ADDR_W-1:0]         o_bram_addr,
  output logic                      o_bram_en,
  input  logic [DATA_W-1:0]         i_bram_dout,
  output logic [N_REQ-1:0]          o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_rsp_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || RD_LAT < 1 || RD_LAT > 2 ||
      MAX_ADDR >= (1 << ADDR_W)) begin : g_bad_param
    $error("ii_read_arbiter: unsupported parameter set");
  end

  logic [ADDR_W-1:0] w_addr_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_addr_arr[g] = i_req_addr[g*ADDR_W +: ADDR_W];
  end

  logic [PTR_W-1:0]  r_last;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [N_REQ-1:0]  r_tag [RD_LAT];

  logic [N_REQ-1:0]  w_grant;
  logic [PTR_W-1:0]  w_grant_idx;
  logic [ADDR_W-1:0] w_grant_addr;
  logic              w_grant_any;
  logic [PTR_W-1:0]  w_idx;
  int                w_sum;

  // Search starts one past the last winner so a held requester yields to any waiter.
  // Reset and a missing frame both suppress the grant so nothing leaks out while idle.
  always_comb begin
    w_grant      = '0;
    w_grant_idx  = r_last;
    w_grant_addr = r_addr_hold;
    w_grant_any  = 1'b0;
    w_sum        = 0;
    w_idx        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = int'(r_last) + k;
      if (w_sum >= N_REQ) begin
        w_sum = w_sum - N_REQ;
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_grant_any && i_req_valid[w_idx]) begin
        w_grant_any  = 1'b1;
        w_grant_idx  = w_idx;
        w_grant_addr = w_addr_arr[w_idx];
      end
    end
    if (!(i_frame_valid && i_rst_n)) begin
      w_grant_any  = 1'b0;
      w_grant_idx  = r_last;
      w_grant_addr = r_addr_hold;
    end
    if (w_grant_any) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign o_req_ready = w_grant;
  assign o_bram_addr = w_grant_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last      <= PTR_W'(N_REQ - 1);
      r_addr_hold <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      if (w_grant_any) begin
        r_last      <= w_grant_idx;
        r_addr_hold <= w_grant_addr;
      end
      r_tag[0] <= w_grant;
      for (int s = 1; s < RD_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  assign o_rsp_valid = r_tag[RD_LAT-1];

`ifdef II_ARB_BOUND_CHECK_EN
  localparam logic [ADDR_W-1:0] LP_MAX_ADDR = ADDR_W'(MAX_ADDR);

  logic              w_oob;
  logic [RD_LAT-1:0] r_err;

  // Out-of-range requests are consumed but never reach the BRAM; the error rides the tag pipe.
  assign w_oob     = w_grant_any && (w_grant_addr > LP_MAX_ADDR);
  assign o_bram_en = w_grant_any && !w_oob;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= '0;
    end else begin
      r_err[0] <= w_oob;
      for (int s = 1; s < RD_LAT; s++) begin
        r_err[s] <= r_err[s-1];
      end
    end
  end

  assign o_rsp_err  = r_err[RD_LAT-1];
  assign o_rsp_data = r_err[RD_LAT-1] ? '0 : i_bram_dout;
`else
  assign o_bram_en  = w_grant_any;
  assign o_rsp_err  = 1'b0;
  assign o_rsp_data = i_bram_dout;
`endif

endmodule

// File: tb/tb_ii_read_arbiter.sv
// Directed bench for ii_read_arbiter: one instance at RD_LAT=1 and one at RD_LAT=2
// driven by the same requests, each with its own behavioural BRAM returning data = address.
module tb_ii_read_arbiter;

`ifdef II_ARB_BOUND_CHECK_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        frameValid;
  logic [3:0]  reqValid;
  logic [59:0] reqAddr;

  logic [3:0]  ready1, ready2;
  logic [14:0] bramAddr1, bramAddr2;
  logic        bramEn1, bramEn2;
  logic [31:0] bramDout1, bramDout2, stage2;
  logic [3:0]  rspValid1, rspValid2;
  logic [31:0] rspData1, rspData2;
  logic        rspErr1, rspErr2;

  int checkCount = 0;
  int errorCount = 0;

  ii_read_arbiter #(.N_REQ(4), .ADDR_W(15), .DATA_W(32), .RD_LAT(1), .MAX_ADDR(19199)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_valid(frameValid),
    .i_req_valid(reqValid), .i_req_addr(reqAddr), .o_req_ready(ready1),
    .o_bram_addr(bramAddr1), .o_bram_en(bramEn1), .i_bram_dout(bramDout1),
    .o_rsp_valid(rspValid1), .o_rsp_data(rspData1), .o_rsp_err(rspErr1)
  );

  ii_read_arbiter #(.N_REQ(4), .ADDR_W(15), .DATA_W(32), .RD_LAT(2), .MAX_ADDR(19199)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_valid(frameValid),
    .i_req_valid(reqValid), .i_req_addr(reqAddr), .o_req_ready(ready2),
    .o_bram_addr(bramAddr2), .o_bram_en(bramEn2), .i_bram_dout(bramDout2),
    .o_rsp_valid(rspValid2), .o_rsp_data(rspData2), .o_rsp_err(rspErr2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM models: every word holds its own address.
  always @(posedge clk) begin
    if (bramEn1) bramDout1 <= 32'(bramAddr1);
    if (bramEn2) stage2 <= 32'(bramAddr2);
    bramDout2 <= stage2;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fv, input logic [3:0] vld);
    @(posedge clk);
    #1;
    frameValid = fv;
    reqValid   = vld;
  endtask

  task automatic checkCycle(input string tag, input logic [3:0] expReady, input logic expEn,
                            input logic [14:0] expAddr, input logic [3:0] expRsp1, input logic [31:0] expData1,
                            input logic [3:0] expRsp2, input logic [31:0] expData2);
    checkOutput({tag, " ready1"}, 32'(ready1), 32'(expReady));
    checkOutput({tag, " ready2"}, 32'(ready2), 32'(expReady));
    checkOutput({tag, " en1"}, 32'(bramEn1), 32'(expEn));
    checkOutput({tag, " en2"}, 32'(bramEn2), 32'(expEn));
    checkOutput({tag, " addr1"}, 32'(bramAddr1), 32'(expAddr));
    checkOutput({tag, " addr2"}, 32'(bramAddr2), 32'(expAddr));
    checkOutput({tag, " rsp1"}, 32'(rspValid1), 32'(expRsp1));
    checkOutput({tag, " rsp2"}, 32'(rspValid2), 32'(expRsp2));
    checkOutput({tag, " err1"}, 32'(rspErr1), 32'd0);
    checkOutput({tag, " err2"}, 32'(rspErr2), 32'd0);
    if (expRsp1 != 4'd0) checkOutput({tag, " data1"}, rspData1, expData1);
    if (expRsp2 != 4'd0) checkOutput({tag, " data2"}, rspData2, expData2);
  endtask

  function automatic logic [3:0] oneHot(input int i);
    return 4'(1 << i);
  endfunction

  initial begin
    rst_n      = 1'b0;
    frameValid = 1'b0;
    reqValid   = 4'd0;
    reqAddr    = '0;

    // Reset holds every output low even with requests pending.
    #3;
    frameValid = 1'b1;
    reqValid   = 4'hF;
    #1;
    checkCycle("inReset", 4'd0, 1'b0, 15'd0, 4'd0, 32'd0, 4'd0, 32'd0);
    frameValid = 1'b0;
    reqValid   = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0);

    // All four held: strict rotation, one read per cycle.
    reqAddr = {15'd203, 15'd202, 15'd201, 15'd200};
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 4'hF);
      @(negedge clk);
      checkCycle($sformatf("rr%0d", c), oneHot(c % 4), 1'b1, 15'(200 + c % 4),
                 (c >= 1) ? oneHot((c - 1) % 4) : 4'd0, 32'(200 + (c + 3) % 4),
                 (c >= 2) ? oneHot((c - 2) % 4) : 4'd0, 32'(200 + (c + 2) % 4));
    end
    applyStimulus(1'b1, 4'd0);
    @(negedge clk);
    checkCycle("rrTail0", 4'd0, 1'b0, 15'd203, 4'b1000, 32'd203, 4'b0100, 32'd202);
    applyStimulus(1'b1, 4'd0);
    @(negedge clk);
    checkCycle("rrTail1", 4'd0, 1'b0, 15'd203, 4'd0, 32'd0, 4'b1000, 32'd203);

    // Requesters 1 and 3; frame_valid drops after the second grant.
    reqAddr = {15'd303, 15'd0, 15'd300, 15'd0};
    applyStimulus(1'b1, 4'b1010);
    @(negedge clk);
    checkCycle("fv0", 4'b0010, 1'b1, 15'd300, 4'd0, 32'd0, 4'd0, 32'd0);
    applyStimulus(1'b1, 4'b1010);
    @(negedge clk);
    checkCycle("fv1", 4'b1000, 1'b1, 15'd303, 4'b0010, 32'd300, 4'd0, 32'd0);
    applyStimulus(1'b0, 4'b1010);
    @(negedge clk);
    checkCycle("fv2", 4'd0, 1'b0, 15'd303, 4'b1000, 32'd303, 4'b0010, 32'd300);
    applyStimulus(1'b0, 4'b1010);
    @(negedge clk);
    checkCycle("fv3", 4'd0, 1'b0, 15'd303, 4'd0, 32'd0, 4'b1000, 32'd303);
    applyStimulus(1'b1, 4'b1010);
    @(negedge clk);
    checkCycle("fv4", 4'b0010, 1'b1, 15'd300, 4'd0, 32'd0, 4'd0, 32'd0);
    applyStimulus(1'b1, 4'd0);
    @(negedge clk);
    checkCycle("fv5", 4'd0, 1'b0, 15'd300, 4'b0010, 32'd300, 4'd0, 32'd0);
    applyStimulus(1'b1, 4'd0);
    @(negedge clk);
    checkCycle("fv6", 4'd0, 1'b0, 15'd300, 4'd0, 32'd0, 4'b0010, 32'd300);

    // Lone requester 2 at address 100.
    reqAddr = {15'd0, 15'd100, 15'd0, 15'd0};
    applyStimulus(1'b1, 4'b0100);
    @(negedge clk);
    checkCycle("one0", 4'b0100, 1'b1, 15'd100, 4'd0, 32'd0, 4'd0, 32'd0);
    applyStimulus(1'b1, 4'd0);
    @(negedge clk);
    checkCycle("one1", 4'd0, 1'b0, 15'd100, 4'b0100, 32'd100, 4'd0, 32'd0);
    applyStimulus(1'b1, 4'd0);
    @(negedge clk);
    checkCycle("one2", 4'd0, 1'b0, 15'd100, 4'd0, 32'd0, 4'b0100, 32'd100);

    // Address one past the frame: trapped only when bound checking is built in.
    reqAddr = {15'd0, 15'd0, 15'd0, 15'd19200};
    applyStimulus(1'b1, 4'b0001);
    @(negedge clk);
    checkOutput("oob ready1", 32'(ready1), 32'd1);
    checkOutput("oob en1", 32'(bramEn1), BOUND ? 32'd0 : 32'd1);
    checkOutput("oob en2", 32'(bramEn2), BOUND ? 32'd0 : 32'd1);
    applyStimulus(1'b1, 4'd0);
    @(negedge clk);
    checkOutput("oob rsp1", 32'(rspValid1), 32'd1);
    checkOutput("oob err1", 32'(rspErr1), BOUND ? 32'd1 : 32'd0);
    checkOutput("oob data1", rspData1, BOUND ? 32'd0 : 32'd19200);
    checkOutput("oob rsp2 early", 32'(rspValid2), 32'd0);
    applyStimulus(1'b1, 4'd0);
    @(negedge clk);
    checkOutput("oob rsp2", 32'(rspValid2), 32'd1);
    checkOutput("oob err2", 32'(rspErr2), BOUND ? 32'd1 : 32'd0);
    checkOutput("oob data2", rspData2, BOUND ? 32'd0 : 32'd19200);
    checkOutput("oob rsp1 done", 32'(rspValid1), 32'd0);

    // Reset with two reads in flight in the RD_LAT=2 instance.
    reqAddr = {15'd203, 15'd202, 15'd201, 15'd200};
    applyStimulus(1'b1, 4'hF);
    applyStimulus(1'b1, 4'hF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkCycle("midRst", 4'd0, 1'b0, 15'd0, 4'd0, 32'd0, 4'd0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkCycle("postRst0", 4'b0001, 1'b1, 15'd200, 4'd0, 32'd0, 4'd0, 32'd0);
    applyStimulus(1'b1, 4'd0);
    @(negedge clk);
    checkCycle("postRst1", 4'd0, 1'b0, 15'd200, 4'b0001, 32'd200, 4'd0, 32'd0);
    applyStimulus(1'b1, 4'd0);
    @(negedge clk);
    checkCycle("postRst2", 4'd0, 1'b0, 15'd200, 4'd0, 32'd0, 4'b0001, 32'd200);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
